// File: rtl/spi_instr_decoder.sv
// Turns two-byte SPI frames (command, data) into single-cycle register-file
// read/write strobes, returning read data to the bridge for the second byte.
module spi_instr_decoder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              byte_lo,
    output logic [DATA_W-1:0] data_write,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        S_CMD    = 2'd0,
        S_RD_LAT = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    logic rw;
    logic cmd_take;
    logic rd_cap;
    logic rd_next;
    logic wr_next;
    logic err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CMD;
        end else begin
            state <= state_next;
        end
    end

    // Chip-select release overrides everything, including a same-cycle byte.
    always_comb begin
        state_next = state;
        cmd_take   = 1'b0;
        rd_cap     = 1'b0;
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        err_next   = 1'b0;
        if (!cs_active) begin
            state_next = S_CMD;
            err_next   = (state == S_RD_LAT) || (state == S_DATA);
        end else begin
            case (state)
                S_CMD: begin
                    if (byte_sync) begin
                        cmd_take   = 1'b1;
                        rd_next    = !data_in[7];
                        state_next = data_in[7] ? S_DATA : S_RD_LAT;
                    end
                end
                S_RD_LAT: begin
                    // read is high on the first cycle here; data_read is valid the cycle after.
                    if (!read) begin
                        rd_cap     = 1'b1;
                        state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_sync) begin
                        wr_next    = rw;
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_CMD;
                end
            endcase
        end
    end

    // Registered strobes and latched command/data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read       <= 1'b0;
            write      <= 1'b0;
            frame_err  <= 1'b0;
            rw         <= 1'b0;
            byte_lo    <= 1'b0;
            addr       <= '0;
            data_out   <= '0;
            data_write <= '0;
        end else begin
            read      <= rd_next;
            write     <= wr_next;
            frame_err <= err_next;
            if (cmd_take) begin
                rw      <= data_in[7];
                byte_lo <= data_in[6];
                addr    <= data_in[ADDR_W-1:0];
            end
            if (rd_cap) begin
                data_out <= data_read;
            end
            if (wr_next) begin
                data_write <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: drives SPI byte frames and checks
// strobes, latched fields, read return data and abort handling.
module tb_spi_instr_decoder;

    logic       clk;
    logic       rst;
    logic       cs_active;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_read;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic       byte_lo;
    logic [7:0] data_write;
    logic       frame_err;

    int n_checks;
    int n_fails;
    int wr_cnt;
    int rd_cnt;
    int err_cnt;
    int both_cnt;
    int wr_base;
    int rd_base;
    int err_base;

    logic [7:0] regmem [64];

    spi_instr_decoder #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_active  (cs_active),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_read  (data_read),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .byte_lo    (byte_lo),
        .data_write (data_write),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (read) data_read <= regmem[addr];
    end

    always @(negedge clk) begin
        if (write) wr_cnt++;
        if (read) rd_cnt++;
        if (frame_err) err_cnt++;
        if (read && write) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_in   = b;
        byte_sync = 1'b1;
        tick();
        byte_sync = 1'b0;
    endtask

    task automatic mark();
        wr_base  = wr_cnt;
        rd_base  = rd_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        wr_cnt    = 0;
        rd_cnt    = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        data_read = 8'h00;
        for (int i = 0; i < 64; i++) regmem[i] = 8'(i + 8'h20);
        regmem[8] = 8'h5A;

        rst       = 1'b1;
        cs_active = 1'b0;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        tick();
        tick();
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_addr", {26'd0, addr}, 32'd0);
        check("rst_byte_lo", {31'd0, byte_lo}, 32'd0);
        check("rst_data_write", {24'd0, data_write}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Low-byte write frame 0xC0, 0x07
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hC0);
        check("wr_cmd_no_read", {31'd0, read}, 32'd0);
        tick();
        send(8'h07);
        check("wr_strobe", {31'd0, write}, 32'd1);
        check("wr_addr", {26'd0, addr}, 32'h00);
        check("wr_byte_lo", {31'd0, byte_lo}, 32'd1);
        check("wr_data", {24'd0, data_write}, 32'h07);
        tick();
        check("wr_strobe_single", {31'd0, write}, 32'd0);
        cs_active = 1'b0;
        tick();
        tick();
        check("wr_count", wr_cnt - wr_base, 32'd1);
        check("wr_no_reads", rd_cnt - rd_base, 32'd0);
        check("wr_no_err", err_cnt - err_base, 32'd0);

        // Read frame 0x48 with register returning 0x5A
        mark();
        cs_active = 1'b1;
        tick();
        send(8'h48);
        check("rd_strobe_t1", {31'd0, read}, 32'd1);
        check("rd_addr", {26'd0, addr}, 32'h08);
        check("rd_byte_lo", {31'd0, byte_lo}, 32'd1);
        check("rd_dout_t1", {24'd0, data_out}, 32'h00);
        tick();
        check("rd_strobe_t2", {31'd0, read}, 32'd0);
        check("rd_dout_t2", {24'd0, data_out}, 32'h00);
        tick();
        check("rd_dout_t3", {24'd0, data_out}, 32'h5A);
        tick();
        send(8'h33);
        check("rd_second_no_write", {31'd0, write}, 32'd0);
        tick();
        cs_active = 1'b0;
        tick();
        tick();
        check("rd_count", rd_cnt - rd_base, 32'd1);
        check("rd_no_writes", wr_cnt - wr_base, 32'd0);
        check("rd_no_err", err_cnt - err_base, 32'd0);
        check("rd_dout_held", {24'd0, data_out}, 32'h5A);

        // High-byte write 0x80, 0x12
        mark();
        cs_active = 1'b1;
        tick();
        send(8'h80);
        tick();
        send(8'h12);
        check("hi_strobe", {31'd0, write}, 32'd1);
        check("hi_addr", {26'd0, addr}, 32'h00);
        check("hi_byte_lo", {31'd0, byte_lo}, 32'd0);
        check("hi_data", {24'd0, data_write}, 32'h12);
        cs_active = 1'b0;
        tick();
        tick();

        // Abort a write frame before its data byte
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hC3);
        tick();
        cs_active = 1'b0;
        tick();
        check("abort_err_pulse", {31'd0, frame_err}, 32'd1);
        tick();
        check("abort_err_clear", {31'd0, frame_err}, 32'd0);
        check("abort_no_write", wr_cnt - wr_base, 32'd0);
        check("abort_err_count", err_cnt - err_base, 32'd1);

        // Following frame writes normally
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hC3);
        tick();
        send(8'h02);
        check("post_abort_strobe", {31'd0, write}, 32'd1);
        check("post_abort_addr", {26'd0, addr}, 32'h03);
        check("post_abort_data", {24'd0, data_write}, 32'h02);
        cs_active = 1'b0;
        tick();
        tick();

        // Data byte arriving in the same cycle chip-select drops is discarded
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hC5);
        tick();
        data_in   = 8'hAA;
        byte_sync = 1'b1;
        cs_active = 1'b0;
        tick();
        byte_sync = 1'b0;
        check("race_err", {31'd0, frame_err}, 32'd1);
        check("race_no_write", {31'd0, write}, 32'd0);
        tick();
        tick();
        check("race_wr_count", wr_cnt - wr_base, 32'd0);

        // Trailing bytes within one frame are ignored
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hCC);
        tick();
        send(8'h01);
        check("extra_addr", {26'd0, addr}, 32'h0C);
        check("extra_data", {24'd0, data_write}, 32'h01);
        tick();
        send(8'hFF);
        tick();
        send(8'hFF);
        tick();
        cs_active = 1'b0;
        tick();
        tick();
        check("extra_wr_count", wr_cnt - wr_base, 32'd1);
        check("extra_rd_count", rd_cnt - rd_base, 32'd0);
        check("extra_no_err", err_cnt - err_base, 32'd0);

        // Asynchronous reset in the middle of a frame
        mark();
        cs_active = 1'b1;
        tick();
        send(8'hCD);
        check("mid_addr_before", {26'd0, addr}, 32'h0D);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_addr", {26'd0, addr}, 32'h00);
        check("mid_rst_byte_lo", {31'd0, byte_lo}, 32'd0);
        check("mid_rst_data_out", {24'd0, data_out}, 32'h00);
        check("mid_rst_data_write", {24'd0, data_write}, 32'h00);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        // After reset this byte is taken as a new write command, not as data.
        send(8'h9A);
        tick();
        tick();
        check("mid_no_write", wr_cnt - wr_base, 32'd0);
        check("mid_cmd_addr", {26'd0, addr}, 32'h1A);
        cs_active = 1'b0;
        tick();
        tick();
        check("mid_err_count", err_cnt - err_base, 32'd1);

        mark();
        cs_active = 1'b1;
        tick();
        send(8'h8E);
        tick();
        send(8'h3C);
        check("after_rst_strobe", {31'd0, write}, 32'd1);
        check("after_rst_addr", {26'd0, addr}, 32'h0E);
        check("after_rst_byte_lo", {31'd0, byte_lo}, 32'd0);
        check("after_rst_data", {24'd0, data_write}, 32'h3C);
        cs_active = 1'b0;
        tick();
        tick();
        check("after_rst_wr_count", wr_cnt - wr_base, 32'd1);
        check("never_read_and_write", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
